uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Baud ticks per bit period
  localparam int OVERSAMPLE = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through TX FIFO.
// Frame: start bit, DBIT data bits LSB first, optional parity bit, stop interval.
// Bit timing counts s_tick pulses only, so it does not depend on clk-to-tick phase.
//
// state | meaning
// IDLE  | line high, waiting for a word in the FIFO
// START | line low for one bit period
// DATA  | shifting data bits out, LSB first
// PAR   | parity bit computed from the word taken at load
// STOP  | line high for SB_TICK ticks, then done pulse
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // Tick counter must hold SB_TICK-1 for long stop intervals (32 ticks -> 5 bits)
  localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int NW = $clog2(DBIT + 1);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_e     state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic            par_bit;
  logic            par_load;

  // Pop strobe: only in IDLE with a word available; held off while in reset
  assign fifo_rd = (state == IDLE) && !fifo_empty && !reset;

  // Parity of the head word, captured together with the word at load
  assign par_load = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);

  // Frame sequencer; tx, tx_busy and tx_done_tick are all registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (!fifo_empty) begin
            shreg   <= fifo_rdata;
            par_bit <= par_load;
            s       <= '0;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
              tx    <= shreg[0];
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              shreg <= shreg >> 1;
              if (n == N_LAST) begin
                if (PARITY != PAR_NONE) begin
                  state <= PAR;
                  tx    <= par_bit;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                n  <= n + 1'b1;
                tx <= shreg[1];
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        PAR: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP_LAST) begin
              s            <= '0;
              state        <= IDLE;
              tx           <= 1'b1;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
